// File: rtl/ct_ifu_spsram_512x44_ctrl_if.sv
// Requester-side bundle: fetch read port and update write port of the IFU SRAM controller.
interface ct_ifu_spsram_512x44_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 44
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_rdy;

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask,
    input  rd_gnt, rd_vld, rd_data, wr_rdy
  );

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask,
    output rd_gnt, rd_vld, rd_data, wr_rdy
  );
endinterface

// File: rtl/ct_ifu_spsram_512x44_ctrl.sv
// Single-port SRAM access controller: init/invalidate sweep, 1-entry write buffer,
// read/write arbitration with RAW ordering and a bounded read-starvation window.
module ct_ifu_spsram_512x44_ctrl #(
  parameter int unsigned           ADDR_WIDTH   = 9,
  parameter int unsigned           DATA_WIDTH   = 44,
  parameter int unsigned           STARVE_LIMIT = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_DATA    = '0
) (
  input  logic                          forever_cpuclk,
  input  logic                          cpurst,
  input  logic                          inv_req,
  output logic                          init_busy,
  ct_ifu_spsram_512x44_ctrl_if.slave    bus,
  output logic                          sram_cen,
  output logic                          sram_gwen,
  output logic [DATA_WIDTH-1:0]         sram_wen,
  output logic [ADDR_WIDTH-1:0]         sram_a,
  output logic [DATA_WIDTH-1:0]         sram_d,
  input  logic [DATA_WIDTH-1:0]         sram_q
);

  localparam int unsigned           CNT_WIDTH  = 4;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = '1;
  localparam logic [CNT_WIDTH-1:0]  STARVE_MAX = CNT_WIDTH'(STARVE_LIMIT);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic                  wbuf_vld_q, wbuf_vld_d;
  logic [ADDR_WIDTH-1:0] wbuf_addr_q;
  logic [DATA_WIDTH-1:0] wbuf_data_q;
  logic [DATA_WIDTH-1:0] wbuf_mask_q;
  logic [CNT_WIDTH-1:0]  starve_cnt_q, starve_cnt_d;
  logic                  inv_pend_q, inv_pend_d;
  logic                  rd_vld_q;
  logic                  wr_issue;
  logic                  rd_issue;
  logic                  wr_accept;

  // Next-state, port arbitration and SRAM pin drive
  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    wbuf_vld_d   = wbuf_vld_q;
    starve_cnt_d = starve_cnt_q;
    inv_pend_d   = inv_pend_q;
    wr_issue     = 1'b0;
    rd_issue     = 1'b0;
    wr_accept    = 1'b0;
    bus.rd_gnt   = 1'b0;
    bus.wr_rdy   = 1'b0;
    sram_cen     = 1'b1;
    sram_gwen    = 1'b1;
    sram_wen     = '1;
    sram_a       = '0;
    sram_d       = '0;

    case (state_q)
      ST_INIT: begin
        sram_cen   = 1'b0;
        sram_gwen  = 1'b0;
        sram_wen   = '0;
        sram_a     = init_cnt_q;
        sram_d     = INIT_DATA;
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        // Buffered write wins when reads are absent, starving, or hitting its address
        wr_issue   = wbuf_vld_q && (!bus.rd_req || (starve_cnt_q == STARVE_MAX) ||
                                    (bus.rd_addr == wbuf_addr_q));
        rd_issue   = !wr_issue && bus.rd_req;
        bus.rd_gnt = rd_issue;
        bus.wr_rdy = !inv_pend_q && (!wbuf_vld_q || wr_issue);
        wr_accept  = bus.wr_req && bus.wr_rdy;

        if (wr_issue) begin
          sram_cen     = 1'b0;
          sram_gwen    = 1'b0;
          sram_wen     = ~wbuf_mask_q;
          sram_a       = wbuf_addr_q;
          sram_d       = wbuf_data_q;
          starve_cnt_d = '0;
        end else if (rd_issue) begin
          sram_cen = 1'b0;
          sram_a   = bus.rd_addr;
          if (wbuf_vld_q) begin
            starve_cnt_d = starve_cnt_q + CNT_WIDTH'(1);
          end
        end

        if (wr_accept) begin
          wbuf_vld_d = 1'b1;
        end else if (wr_issue) begin
          wbuf_vld_d = 1'b0;
        end

        // Invalidate waits for the write buffer to drain before restarting the sweep
        if (inv_pend_q && (!wbuf_vld_q || wr_issue)) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
          inv_pend_d = 1'b0;
        end else if (inv_req) begin
          inv_pend_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control state registers
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      state_q      <= ST_INIT;
      init_cnt_q   <= '0;
      wbuf_vld_q   <= 1'b0;
      starve_cnt_q <= '0;
      inv_pend_q   <= 1'b0;
      rd_vld_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      wbuf_vld_q   <= wbuf_vld_d;
      starve_cnt_q <= starve_cnt_d;
      inv_pend_q   <= inv_pend_d;
      rd_vld_q     <= rd_issue;
    end
  end

  // Write buffer payload; only meaningful while wbuf_vld_q is set
  always_ff @(posedge forever_cpuclk) begin
    if (wr_accept) begin
      wbuf_addr_q <= bus.wr_addr;
      wbuf_data_q <= bus.wr_data;
      wbuf_mask_q <= bus.wr_mask;
    end
  end

  assign init_busy   = (state_q == ST_INIT) || inv_pend_q;
  assign bus.rd_vld  = rd_vld_q;
  assign bus.rd_data = sram_q;

endmodule

// File: tb/tb_ct_ifu_spsram_512x44_ctrl.sv
// Bench for the IFU SRAM controller: SRAM macro model, golden-memory reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_ct_ifu_spsram_512x44_ctrl;
  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 44;
  localparam int          LIMIT = 4;
  localparam int          DEPTH = 512;

  logic          clk;
  logic          cpurst;
  logic          inv_req;
  logic          init_busy;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  ct_ifu_spsram_512x44_ctrl_if bus ();

  ct_ifu_spsram_512x44_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
    .forever_cpuclk (clk),
    .cpurst         (cpurst),
    .inv_req        (inv_req),
    .init_busy      (init_busy),
    .bus            (bus),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro: registered read data, bit-masked write (wen active low)
  logic [DW-1:0] sram_mem [DEPTH];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (sram_gwen) sram_q <= sram_mem[sram_a];
      else sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: transaction-level view with a golden memory image
  bit            m_known = 1'b0;
  bit            m_init, m_pend, m_inv, m_prev_gnt;
  int            m_sweep, m_reads;
  logic [AW-1:0] m_paddr;
  logic [DW-1:0] m_pdata, m_pmask, m_prev_val;
  logic [DW-1:0] golden [DEPTH];
  bit            e_wfire, e_gnt, e_rdy, e_busy, e_cen, e_gwen;
  logic [DW-1:0] e_wen, e_d;
  logic [AW-1:0] e_a;

  // Every-cycle compare against the reference model
  always @(negedge clk) begin
    if (m_known) begin
      e_wfire = 1'b0; e_gnt = 1'b0; e_rdy = 1'b0; e_cen = 1'b1; e_gwen = 1'b1;
      e_wen = '1; e_a = '0; e_d = '0;
      if (m_init) begin
        e_busy = 1'b1; e_cen = 1'b0; e_gwen = 1'b0; e_wen = '0; e_a = AW'(m_sweep); e_d = '0;
      end else begin
        e_busy  = m_inv;
        e_wfire = m_pend && (!bus.rd_req || m_reads == LIMIT || bus.rd_addr == m_paddr);
        e_gnt   = !e_wfire && bus.rd_req;
        e_rdy   = !m_inv && (!m_pend || e_wfire);
        if (e_wfire) begin
          e_cen = 1'b0; e_gwen = 1'b0; e_wen = ~m_pmask; e_a = m_paddr; e_d = m_pdata;
        end else if (e_gnt) begin
          e_cen = 1'b0; e_a = bus.rd_addr;
        end
      end
      check("init_busy", 64'(init_busy), 64'(e_busy));
      check("rd_gnt", 64'(bus.rd_gnt), 64'(e_gnt));
      check("wr_rdy", 64'(bus.wr_rdy), 64'(e_rdy));
      check("sram_cen", 64'(sram_cen), 64'(e_cen));
      check("sram_gwen", 64'(sram_gwen), 64'(e_gwen));
      check("sram_wen", 64'(sram_wen), 64'(e_wen));
      check("sram_a", 64'(sram_a), 64'(e_a));
      check("sram_d", 64'(sram_d), 64'(e_d));
      check("rd_vld", 64'(bus.rd_vld), 64'(m_prev_gnt));
      if (m_prev_gnt) check("rd_data", 64'(bus.rd_data), 64'(m_prev_val));

      if (m_init) golden[m_sweep] = '0;
      else if (e_wfire) golden[m_paddr] = (golden[m_paddr] & ~m_pmask) | (m_pdata & m_pmask);
      m_prev_gnt = e_gnt;
      if (e_gnt) m_prev_val = golden[bus.rd_addr];

      if (m_init) begin
        if (m_sweep == DEPTH - 1) m_init = 1'b0;
        else m_sweep++;
      end else begin
        if (e_wfire) m_reads = 0;
        else if (e_gnt && m_pend) m_reads++;
        if (m_inv && (!m_pend || e_wfire)) begin
          m_init = 1'b1; m_sweep = 0; m_inv = 1'b0;
        end else if (inv_req) begin
          m_inv = 1'b1;
        end
        if (bus.wr_req && e_rdy) begin
          m_pend = 1'b1; m_paddr = bus.wr_addr; m_pdata = bus.wr_data; m_pmask = bus.wr_mask;
        end else if (e_wfire) begin
          m_pend = 1'b0;
        end
      end
    end
    if (cpurst) begin
      m_known = 1'b1; m_init = 1'b1; m_sweep = 0; m_pend = 1'b0;
      m_reads = 0; m_inv = 1'b0; m_prev_gnt = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits out a sweep starting at the next sampled cycle and checks its length
  task automatic sweep_wait();
    int n = 0;
    bit done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      @(negedge clk);
      if (i == 0) begin
        check("sweep_first_a", 64'(sram_a), 64'(0));
        check("sweep_first_rd_vld", 64'(bus.rd_vld), 64'(0));
      end
      if (!init_busy) done = 1'b1;
      else n++;
    end
    check("sweep_done", 64'(done), 64'(1));
    check("sweep_len", 64'(n), 64'(512));
  endtask

  // Write then hazard read of the same address, expecting merged data
  task automatic raw(input logic [DW-1:0] data, input logic [DW-1:0] mask, input logic [DW-1:0] expv);
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = 9'h033; bus.wr_data = data; bus.wr_mask = mask;
    bus.rd_req = 1'b1; bus.rd_addr = 9'h020;
    tick();
    bus.wr_req = 1'b0; bus.rd_addr = 9'h033;
    @(negedge clk);
    check("raw_write_first_gwen", 64'(sram_gwen), 64'(0));
    check("raw_write_first_a", 64'(sram_a), 64'(9'h033));
    check("raw_write_first_gnt", 64'(bus.rd_gnt), 64'(0));
    tick();
    @(negedge clk);
    check("raw_read_gnt", 64'(bus.rd_gnt), 64'(1));
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("raw_rd_vld", 64'(bus.rd_vld), 64'(1));
    check("raw_rd_data", 64'(bus.rd_data), 64'(expv));
  endtask

  // Single read expecting a literal value
  task automatic read_expect(input logic [AW-1:0] addr, input logic [DW-1:0] expv);
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = addr;
    @(negedge clk);
    check("rd_gnt_single", 64'(bus.rd_gnt), 64'(1));
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("rd_vld_single", 64'(bus.rd_vld), 64'(1));
    check("rd_data_single", 64'(bus.rd_data), 64'(expv));
  endtask

  initial begin
    int n;
    bit hit;
    bit g;
    logic [63:0] r64;
    logic [63:0] m64;

    cpurst = 1'b1; inv_req = 1'b0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.wr_req = 1'b0;
    bus.wr_addr = '0; bus.wr_data = '0; bus.wr_mask = '0;
    tick();
    tick();
    cpurst = 1'b0;
    bus.rd_req = 1'b1; bus.rd_addr = 9'h100;
    sweep_wait();

    // Plain write then read back
    tick();
    bus.rd_req = 1'b0;
    bus.wr_req = 1'b1; bus.wr_addr = 9'h1A5; bus.wr_data = 44'hABC_DEF0_1234; bus.wr_mask = '1;
    @(negedge clk);
    check("wr_rdy_empty", 64'(bus.wr_rdy), 64'(1));
    tick();
    bus.wr_req = 1'b0;
    @(negedge clk);
    check("wr_issue_gwen", 64'(sram_gwen), 64'(0));
    check("wr_issue_a", 64'(sram_a), 64'(9'h1A5));
    tick();
    bus.rd_req = 1'b1; bus.rd_addr = 9'h1A5;
    @(negedge clk);
    check("rd_gnt_1a5", 64'(bus.rd_gnt), 64'(1));
    tick();
    bus.rd_req = 1'b0;
    @(negedge clk);
    check("rd_vld_1a5", 64'(bus.rd_vld), 64'(1));
    check("rd_data_1a5", 64'(bus.rd_data), 64'(44'hABC_DEF0_1234));

    // Starvation window: continuous reads on another address
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = 9'h010; bus.wr_data = 44'h0AA_0000_0055; bus.wr_mask = '1;
    bus.rd_req = 1'b1; bus.rd_addr = 9'h020;
    @(negedge clk);
    check("starve_accept_gnt", 64'(bus.rd_gnt), 64'(1));
    tick();
    bus.wr_req = 1'b0;
    n = 0; hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(negedge clk);
      if (!sram_gwen) hit = 1'b1;
      else begin
        if (bus.rd_gnt) n++;
        tick();
      end
    end
    check("starve_write_seen", 64'(hit), 64'(1));
    check("starve_read_count", 64'(n), 64'(4));
    check("starve_write_a", 64'(sram_a), 64'(9'h010));
    check("starve_write_no_gnt", 64'(bus.rd_gnt), 64'(0));
    tick();
    @(negedge clk);
    check("starve_reads_resume", 64'(bus.rd_gnt), 64'(1));
    check("starve_reads_resume_a", 64'(sram_a), 64'(9'h020));

    // RAW ordering, full then partial mask
    raw(44'h123_4567_89AB, '1, 44'h123_4567_89AB);
    raw(44'hFED_CBA9_8765, 44'h000_0000_FFFF, 44'h123_4567_8765);

    // Invalidate with a buffered write
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = 9'h050; bus.wr_data = 44'h555_5555_5555; bus.wr_mask = '1;
    inv_req = 1'b1; bus.rd_req = 1'b1; bus.rd_addr = 9'h060;
    @(negedge clk);
    check("inv_cycle_wr_rdy", 64'(bus.wr_rdy), 64'(1));
    check("inv_cycle_rd_gnt", 64'(bus.rd_gnt), 64'(1));
    tick();
    inv_req = 1'b0; bus.wr_addr = 9'h051; bus.rd_req = 1'b0;
    @(negedge clk);
    check("inv_pend_wr_rdy", 64'(bus.wr_rdy), 64'(0));
    check("inv_pend_busy", 64'(init_busy), 64'(1));
    check("inv_drain_gwen", 64'(sram_gwen), 64'(0));
    check("inv_drain_a", 64'(sram_a), 64'(9'h050));
    tick();
    bus.wr_req = 1'b0;
    sweep_wait();
    read_expect(9'h050, '0);
    read_expect(9'h1A5, '0);
    read_expect(AW'($urandom_range(0, DEPTH - 1)), '0);

    // Reset in RUN with a write being accepted and a read granted
    tick();
    bus.wr_req = 1'b1; bus.wr_addr = 9'h077; bus.wr_data = 44'h0F0_F0F0_F0F0; bus.wr_mask = '1;
    bus.rd_req = 1'b1; bus.rd_addr = 9'h078; cpurst = 1'b1;
    tick();
    cpurst = 1'b0; bus.wr_req = 1'b0; bus.rd_req = 1'b0;
    sweep_wait();
    read_expect(9'h077, '0);

    // Reset mid-sweep at address 200
    tick();
    inv_req = 1'b1;
    tick();
    inv_req = 1'b0;
    @(negedge clk);
    check("inv_empty_busy", 64'(init_busy), 64'(1));
    tick();
    hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      if (init_busy && sram_a == 9'd199) hit = 1'b1;
      else tick();
    end
    check("sweep_reach_199", 64'(hit), 64'(1));
    tick();
    cpurst = 1'b1;
    @(negedge clk);
    check("reset_at_a", 64'(sram_a), 64'(200));
    tick();
    cpurst = 1'b0;
    sweep_wait();

    // Randomized traffic on a small address window to provoke hazards
    for (int i = 0; i < 4000; i++) begin
      g = bus.rd_gnt;
      tick();
      if (!bus.rd_req || g) begin
        bus.rd_req  = ($urandom_range(0, 2) != 0);
        bus.rd_addr = AW'($urandom_range(0, 15));
      end
      bus.wr_req  = ($urandom_range(0, 1) != 0);
      bus.wr_addr = AW'($urandom_range(0, 15));
      r64 = {$urandom(), $urandom()};
      m64 = {$urandom(), $urandom()};
      bus.wr_data = r64[DW-1:0];
      bus.wr_mask = ($urandom_range(0, 1) != 0) ? '1 : m64[DW-1:0];
      inv_req = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end
    tick();
    bus.rd_req = 1'b0; bus.wr_req = 1'b0; inv_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
